// File: rtl/mema_seq_pkg.sv
// Shared types and helpers for the memA read sequencer and its row-by-vector consumers.
package mema_seq_pkg;

  localparam int unsigned COUNT_W = 32;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ISSUE      = 3'd1,
    S_STREAM     = 3'd2,
    S_WAIT_READY = 3'd3,
    S_NEXT       = 3'd4,
    S_DONE       = 3'd5
  } seq_state_t;

  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/mema_read_sequencer_stream_down_counter.sv
// Loadable down-counter that saturates at zero; times the chunk stream of one row group.
module stream_down_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero_c
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_zero_c = (r_count == '0);

endmodule

// File: rtl/mema_read_sequencer.sv
// Walks memA row-group addresses, pulses read_preprocess per group and waits for
// every row-by-vector module to report ready before moving to the next group.
module mema_read_sequencer
  import mema_seq_pkg::*;
#(
  parameter int unsigned no_of_elements_on_col_nos   = 20,
  parameter int unsigned no_of_row_by_vector_modules = 4,
  parameter int unsigned no_of_units                 = 8,
  parameter int unsigned no_of_row_groups            = 5,
  parameter int unsigned base_address                = 0
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic                                           start,
  input  logic [no_of_row_by_vector_modules-1:0]         I_am_ready,
  output logic [COUNT_W-1:0]                             memA_read_address,
  output logic                                           read_preprocess,
  output logic [COUNT_W*no_of_row_by_vector_modules-1:0] no_of_multiples,
  output logic [COUNT_W-1:0]                             group_index,
  output logic                                           busy,
  output logic                                           done
);

  localparam int unsigned M             = no_of_row_by_vector_modules;
  localparam int unsigned MULT          = ceil_div(no_of_elements_on_col_nos, no_of_units);
  // One chunk every two clocks plus the two-stage index pipeline in the consumers.
  localparam int unsigned STREAM_CYCLES = 2 * MULT + 2;
  localparam int unsigned CNT_W         = $clog2(STREAM_CYCLES + 1);
  localparam int unsigned LAST_GROUP    = no_of_row_groups - 1;

  seq_state_t                 r_state;
  logic [COUNT_W-1:0]         r_addr;
  logic [COUNT_W-1:0]         r_group;
  logic                       r_preprocess;
  logic                       r_busy;
  logic                       r_done;
  logic [COUNT_W*M-1:0]       r_multiples;
  logic                       w_stream_zero;

  stream_down_counter #(
    .WIDTH (CNT_W)
  ) u_stream_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (r_state == S_ISSUE),
    .i_load_val (CNT_W'(STREAM_CYCLES - 1)),
    .i_dec      (r_state == S_STREAM),
    .o_zero_c   (w_stream_zero)
  );

  // Outputs are registered alongside the state they belong to, so they line up with it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_addr       <= COUNT_W'(base_address);
      r_group      <= '0;
      r_preprocess <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_multiples  <= {M{COUNT_W'(MULT)}};
    end else begin
      r_preprocess <= 1'b0;
      r_done       <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state      <= S_ISSUE;
            r_preprocess <= 1'b1;
            r_busy       <= 1'b1;
          end
        end
        S_ISSUE: begin
          r_state <= S_STREAM;
        end
        S_STREAM: begin
          if (w_stream_zero) begin
            r_state <= S_WAIT_READY;
          end
        end
        S_WAIT_READY: begin
          if (&I_am_ready) begin
            r_state <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (r_group == COUNT_W'(LAST_GROUP)) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_addr  <= COUNT_W'(base_address);
            r_group <= '0;
          end else begin
            r_state      <= S_ISSUE;
            r_preprocess <= 1'b1;
            r_addr       <= r_addr + COUNT_W'(1);
            r_group      <= r_group + COUNT_W'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign memA_read_address = r_addr;
  assign read_preprocess   = r_preprocess;
  assign no_of_multiples   = r_multiples;
  assign group_index       = r_group;
  assign busy              = r_busy;
  assign done              = r_done;

endmodule
